rca_accum_ctrl: RTL and testbench

- Sequential accumulator stage wrapped around the team's 16-bit ripple-carry adder.
- Accepts a stream of 16-bit operands over a valid/ready handshake and drives the adder with {accumulator, operand}.
- Registers the adder's sum and carry-out, and emits one result beat after NUM_OPS operands.
- The adder is instantiated outside this block; this block owns all state.

---
 rtl/rca_accum_ctrl.sv | 103 ++++++++++
 tb/tb_rca_accum_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rca_accum_ctrl.sv
// Accumulates NUM_OPS operands through an external 16-bit ripple-carry adder and emits one result beat.
// Result is visible the cycle after the last accepted operand; in_ready drops while a result is pending. Optional SAT_EN saturates the sum.
module rca_accum_ctrl #(
  parameter int NUM_OPS = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic [15:0]      add_a,
  output logic [15:0]      add_b,
  output logic             add_cin,
  input  logic [15:0]      add_s,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_sum,
  output logic [CNT_W-1:0] out_carries,
  output logic             out_ovf
);

  typedef enum logic {ACCUM, DONE} state_t;

  state_t           state;
  logic [15:0]      acc;
  logic [15:0]      acc_upd;
  logic [CNT_W-1:0] op_cnt;
  logic [CNT_W-1:0] carry_cnt;
  logic [CNT_W-1:0] carry_upd;
  logic             last;

  assign add_a   = acc;
  assign add_b   = in_data;
  assign add_cin = 1'b0;

  assign last = (op_cnt == CNT_W'(NUM_OPS - 1));

  // Carry counter sticks at all-ones rather than wrapping back to zero.
  assign carry_upd = (add_cout && (carry_cnt != '1)) ? carry_cnt + CNT_W'(1) : carry_cnt;

`ifdef SAT_EN
  assign acc_upd = (add_cout || (carry_cnt != '0)) ? 16'hFFFF : add_s;
`else
  assign acc_upd = add_s;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ACCUM;
      acc         <= '0;
      op_cnt      <= '0;
      carry_cnt   <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_sum     <= '0;
      out_carries <= '0;
      out_ovf     <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (clear) begin
            acc       <= '0;
            op_cnt    <= '0;
            carry_cnt <= '0;
          end else if (in_valid) begin
            if (last) begin
              out_sum     <= acc_upd;
              out_carries <= carry_upd;
              out_ovf     <= (carry_upd != '0);
              acc         <= '0;
              op_cnt      <= '0;
              carry_cnt   <= '0;
              state       <= DONE;
              in_ready    <= 1'b0;
              out_valid   <= 1'b1;
            end else begin
              acc       <= acc_upd;
              op_cnt    <= op_cnt + CNT_W'(1);
              carry_cnt <= carry_upd;
            end
          end
        end
        DONE: begin
          // clear and out_ready both release the result; no operand is taken this cycle.
          if (clear || out_ready) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ACCUM;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca_accum_ctrl.sv
// Bench for rca_accum_ctrl: directed scenarios then random groups against an arithmetic reference model.
module tb_rca_accum_ctrl;

  localparam int NOPS = 4;

  logic        clk, rst, clear, in_valid, in_ready, add_cin, add_cout;
  logic        out_valid, out_ready, out_ovf;
  logic [15:0] in_data, add_a, add_b, add_s, out_sum;
  logic [7:0]  out_carries;

  int n_cmp = 0;
  int n_err = 0;

  rca_accum_ctrl #(.NUM_OPS(NOPS), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carries(out_carries), .out_ovf(out_ovf)
  );

  // External ripple-carry adder, modelled behaviourally.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {16'b0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    check("push_wait", 32'(w < 50), 32'd1);
    tick();
    in_valid = 1'b0;
    in_data  = 16'($urandom);
  endtask

  // Reference: the group total split into low 16 bits and the number of 2^16 overflows.
  function automatic void ref_group(input int ops[NOPS], output logic [15:0] s, output logic [7:0] c);
`ifdef SAT_EN
    int a, t, cc;
    a = 0; cc = 0;
    for (int i = 0; i < NOPS; i++) begin
      t = a + ops[i];
      if (t > 65535 || cc != 0) a = 65535; else a = t;
      if (t > 65535) cc++;
    end
    s = 16'(a);
    c = 8'((cc > 255) ? 255 : cc);
`else
    int total;
    total = 0;
    for (int i = 0; i < NOPS; i++) total += ops[i];
    s = 16'(total % 65536);
    c = 8'(total / 65536);
`endif
  endfunction

  task automatic run_group(input int ops[NOPS], input string tag);
    logic [15:0] es;
    logic [7:0]  ec;
    ref_group(ops, es, ec);
    for (int i = 0; i < NOPS; i++) push(16'(ops[i]));
    check({tag, "_vld"}, 32'(out_valid), 32'd1);
    check({tag, "_sum"}, 32'(out_sum), 32'(es));
    check({tag, "_car"}, 32'(out_carries), 32'(ec));
    check({tag, "_ovf"}, 32'(out_ovf), 32'(ec != 0));
  endtask

  initial begin
    int ops[NOPS];
    logic [15:0] held;
    clear = 0; in_valid = 0; out_ready = 0; in_data = 16'h0; rst = 0;
    #2 rst = 1;
    tick(); tick();
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_rdy", 32'(in_ready), 32'd1);
    check("rst_sum", 32'(out_sum), 32'd0);
    check("rst_car", 32'(out_carries), 32'd0);
    check("rst_ovf", 32'(out_ovf), 32'd0);
    check("rst_adda", 32'(add_a), 32'd0);
    check("cin", 32'(add_cin), 32'd0);
    #2 rst = 0;
    tick();

    // Operands 1..4 back-to-back with out_ready high.
    out_ready = 1;
    for (int i = 0; i < NOPS; i++) begin
      in_valid = 1; in_data = 16'(i + 1);
      check("t1_rdy", 32'(in_ready), 32'd1);
      check("t1_adda", 32'(add_a), 32'((i * (i + 1)) / 2));
      check("t1_addb", 32'(add_b), 32'(i + 1));
      tick();
    end
    in_data = 16'h0055;
    check("t1_vld", 32'(out_valid), 32'd1);
    check("t1_sum", 32'(out_sum), 32'd10);
    check("t1_car", 32'(out_carries), 32'd0);
    check("t1_ovf", 32'(out_ovf), 32'd0);
    check("t1_bubble", 32'(in_ready), 32'd0);
    tick();
    in_valid = 0;
    check("t1_vld_drop", 32'(out_valid), 32'd0);
    check("t1_rdy_back", 32'(in_ready), 32'd1);
    check("t1_acc0", 32'(add_a), 32'd0);

    // Wrap-around with carries; result left pending.
    out_ready = 0;
    ops = '{32'hFFFF, 32'h0002, 32'h8000, 32'h8000};
    run_group(ops, "t2");
`ifdef SAT_EN
    check("t2_sum_c", 32'(out_sum), 32'hFFFF);
`else
    check("t2_sum_c", 32'(out_sum), 32'h0001);
    check("t2_car_c", 32'(out_carries), 32'd2);
`endif

    // Hold for 10 cycles with an operand offered.
    held = out_sum;
    in_valid = 1; in_data = 16'h1234;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_hold_sum", 32'(out_sum), 32'(held));
      check("t3_hold_rdy", 32'(in_ready), 32'd0);
      check("t3_hold_vld", 32'(out_valid), 32'd1);
    end
    out_ready = 1;
    tick();
    in_valid = 0;
    out_ready = 0;
    check("t3_rel_vld", 32'(out_valid), 32'd0);
    check("t3_rel_sum", 32'(out_sum), 32'(held));
    check("t3_acc0", 32'(add_a), 32'd0);
    ops = '{1, 1, 1, 1};
    run_group(ops, "t3n");
    out_ready = 1; tick(); out_ready = 0;

    // Clear after two operands.
    push(16'd7); push(16'd9);
    clear = 1; in_valid = 1; in_data = 16'd100;
    check("t4_rdy_clr", 32'(in_ready), 32'd1);
    tick();
    clear = 0; in_valid = 0;
    check("t4_acc0", 32'(add_a), 32'd0);
    ops = '{5, 5, 5, 5};
    run_group(ops, "t4");

    // Clear in DONE wins over out_ready.
    clear = 1; out_ready = 1;
    tick();
    clear = 0; out_ready = 0;
    check("t4b_vld", 32'(out_valid), 32'd0);
    check("t4b_rdy", 32'(in_ready), 32'd1);

    // Asynchronous reset while a result is pending.
    ops = '{100, 200, 300, 400};
    run_group(ops, "t5");
    #2 rst = 1;
    #1;
    check("t5_rst_vld", 32'(out_valid), 32'd0);
    check("t5_rst_sum", 32'(out_sum), 32'd0);
    check("t5_rst_rdy", 32'(in_ready), 32'd1);
    #2 rst = 0;
    tick();

    // Random groups with gaps, backpressure and occasional aborted partial groups.
    for (int g = 0; g < 1000; g++) begin
      if ($urandom_range(0, 19) == 0) begin
        push(16'($urandom)); push(16'($urandom));
        clear = 1; tick(); clear = 0;
      end
      for (int i = 0; i < NOPS; i++)
        ops[i] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(16'hC000, 16'hFFFF))
                                              : int'($urandom_range(0, 16'hFFFF));
      begin
        logic [15:0] es;
        logic [7:0]  ec;
        ref_group(ops, es, ec);
        for (int i = 0; i < NOPS; i++) begin
          for (int k = $urandom_range(0, 2); k > 0; k--) tick();
          push(16'(ops[i]));
        end
        for (int k = $urandom_range(0, 3); k > 0; k--) tick();
        check("rnd_vld", 32'(out_valid), 32'd1);
        check("rnd_sum", 32'(out_sum), 32'(es));
        check("rnd_car", 32'(out_carries), 32'(ec));
        check("rnd_ovf", 32'(out_ovf), 32'(ec != 0));
      end
      out_ready = 1; tick(); out_ready = 0;
      check("rnd_rel", 32'(out_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
